// File: rtl/rgb_frame_reader.sv
// rgb_frame_reader: reads the packed RGB frame out of SRAM and streams 24-bit pixels.
// Every three SRAM words carry two pixels; a credit-limited read pipeline feeds a small word FIFO.
module rgb_frame_reader #(
    parameter logic [17:0] BASE_ADDR  = 18'd146944,
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RD_LATENCY = 3
) (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic [7:0]  pix_R,
    output logic [7:0]  pix_G,
    output logic [7:0]  pix_B,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sol,
    output logic        pix_eof
);

    localparam int unsigned AW          = 18;
    localparam int unsigned WCW         = 17;
    localparam int unsigned XW          = 9;
    localparam int unsigned YW          = 8;
    localparam int unsigned LAT         = RD_LATENCY;
    localparam int unsigned PW          = $clog2(FIFO_DEPTH);
    localparam int unsigned CW          = PW + 1;
    localparam int unsigned TOTAL_WORDS = WIDTH * HEIGHT * 3 / 2;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            issue, clear;
    logic [AW-1:0]   addr_q, waddr_q;
    logic [WCW-1:0]  wcnt_q;
    logic [LAT-1:0]  inflight_q;
    logic [15:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [1:0]      phase_q;
    logic [15:0]     w0_q;
    logic [7:0]      r1_q;
    logic            valid_q, sol_q, eof_q;
    logic [23:0]     pix_q, pix_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [31:0]     inflight_cnt;
    logic            credit, last_word, push, pop, load, hs, active;
    logic [15:0]     fifo_word;

    assign hs        = valid_q && pix_ready;
    assign active    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign push      = inflight_q[LAT-1];
    assign pop       = active && (count_q != '0) && (!valid_q || pix_ready);
    assign load      = pop && (phase_q != 2'd0);
    assign fifo_word = fifo_mem[rd_ptr_q];
    assign last_word = (wcnt_q == WCW'(TOTAL_WORDS - 1));

    // Words queued plus words still in the read pipeline must stay below the FIFO depth.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < int'(LAT); i++) begin
            inflight_cnt = inflight_cnt + 32'(inflight_q[i]);
        end
        credit = (32'(count_q) + inflight_cnt) < 32'(FIFO_DEPTH);
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (issue && last_word) state_d = S_DRAIN;
            S_DRAIN: if (hs && eof_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue  = 1'b0;
        clear  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        issue  = (state_q == S_FETCH) && credit;
        clear  = (state_q == S_IDLE) && start;
        busy_d = active;
        done_d = (state_q == S_DONE);
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (hs) begin
            if (x_q == XW'(WIDTH - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
        pix_d = (phase_q == 2'd1) ? {w0_q, fifo_word[15:8]} : {r1_q, fifo_word};
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (push) fifo_mem[wr_ptr_q] <= SRAM_read_data;
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= BASE_ADDR;
            waddr_q    <= BASE_ADDR;
            wcnt_q     <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            phase_q    <= '0;
            w0_q       <= '0;
            r1_q       <= '0;
            valid_q    <= 1'b0;
            pix_q      <= '0;
            sol_q      <= 1'b0;
            eof_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (clear) begin
                addr_q     <= BASE_ADDR;
                waddr_q    <= BASE_ADDR;
                wcnt_q     <= '0;
                inflight_q <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                phase_q    <= '0;
                valid_q    <= 1'b0;
                x_q        <= '0;
                y_q        <= '0;
            end else begin
                inflight_q <= (inflight_q << 1) | LAT'(issue);
                if (issue) begin
                    addr_q  <= waddr_q;
                    waddr_q <= waddr_q + AW'(1);
                    wcnt_q  <= wcnt_q + WCW'(1);
                end
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
                // Phase 0 parks w0, phase 1 emits pixel 0 and keeps R1, phase 2 emits pixel 1.
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                    phase_q  <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                    if (phase_q == 2'd0) w0_q <= fifo_word;
                    if (phase_q == 2'd1) r1_q <= fifo_word[7:0];
                end
                if (load) begin
                    valid_q <= 1'b1;
                    pix_q   <= pix_d;
                    sol_q   <= (x_d == '0);
                    eof_q   <= (x_d == XW'(WIDTH - 1)) && (y_d == YW'(HEIGHT - 1));
                end else if (hs) begin
                    valid_q <= 1'b0;
                end
                x_q <= x_d;
                y_q <= y_d;
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign SRAM_address = addr_q;
    assign SRAM_we_n    = 1'b1;
    assign pix_R        = pix_q[23:16];
    assign pix_G        = pix_q[15:8];
    assign pix_B        = pix_q[7:0];
    assign pix_valid    = valid_q;
    assign pix_sol      = sol_q;
    assign pix_eof      = eof_q;

endmodule

// File: doc/rgb_frame_reader.md
# rgb_frame_reader

Downstream stage of the YUV-to-RGB conversion milestone. Once the converted frame is in SRAM, this block reads the packed RGB region from SRAM and unpacks it into a stream of 24-bit pixels. The stream feeds the display/VGA output path through a valid/ready handshake. The block owns the SRAM port while busy and never writes to SRAM.

## Interface
Parameters:
- BASE_ADDR, 18'd146944: first SRAM word of the packed RGB frame.
- WIDTH, 320: pixels per line (must be even).
- HEIGHT, 240: lines per frame.
- FIFO_DEPTH, 8: capacity of the word FIFO, in 16-bit words (power of 2, ≥4).
- RD_LATENCY, 3: number of clock edges from the edge that registers SRAM_address to the edge that samples SRAM_read_data.

Ports:
- CLOCK_50_I  in  1: 50 MHz clock; the only clock.
- Reset  in  1: synchronous, active-high reset.
- start  in  1: one-cycle pulse that begins a frame read.
- busy  out  1: high from the cycle after an accepted start until the cycle done pulses.
- done  out  1: one-cycle pulse after the last pixel handshake.
- SRAM_address  out  18: registered read address.
- SRAM_we_n  out  1: tied high (read-only).
- SRAM_read_data  in  16: SRAM read data.
- pix_R, pix_G, pix_B  out  8 each: current output pixel.
- pix_valid  out  1: output pixel is valid.
- pix_ready  in  1: consumer accepts the pixel.
- pix_sol  out  1: the current pixel has x==0 (start of line).
- pix_eof  out  1: the current pixel is the last pixel of the frame.

## Operation
- Frame layout: WIDTH*HEIGHT*3/2 words, 115200 with the defaults, at BASE_ADDR..BASE_ADDR+115199 (last word 262143).
- Packing repeats every 3 words / 2 pixels:
  - w0 = {R0,G0}
  - w1 = {B0,R1}
  - w2 = {G1,B1}
- FSM states:
  - IDLE: start → FETCH; clear all counters; word address = BASE_ADDR.
  - FETCH: issue one read per cycle while credit is available. Credit rule: fifo_count + in_flight < FIFO_DEPTH. in_flight is a RD_LATENCY-deep valid shift register. After the last word is issued → DRAIN.
  - DRAIN: issue no reads; wait for in-flight data and for the unpacker to empty. After the final pixel handshake → DONE.
  - DONE: pulse done for one cycle → IDLE.
- Capture: each returning word is pushed into the FIFO at the edge flagged by the tail of the in_flight shift register. The credit rule guarantees the FIFO never overflows.
- Unpacker:
  - A phase counter (0,1,2) pops words from the FIFO.
  - Pixel 0 is formed from w0 plus the high byte of w1. The low byte of w1 (R1) is held in a byte register.
  - Pixel 1 is formed from R1 plus w2.
  - A pop occurs only when the output register is empty, or is being drained that same cycle.
- Output register:
  - Loads a pixel and sets pix_valid.
  - While pix_valid && !pix_ready, all pix_* outputs are held stable.
  - A handshake (pix_valid && pix_ready) advances x (0..WIDTH-1, wraps to 0 and increments y).
  - pix_sol is high when x==0; pix_eof is high when x==WIDTH-1 && y==HEIGHT-1.
- Arithmetic: the address counter is 18 bits; the word counter is 17 bits; x is 9 bits; y is 8 bits. No wraparound of SRAM_address occurs with the defaults.
- start while busy is ignored.
- Reset asserted mid-frame:
  - Returns the FSM to IDLE at the next edge.
  - Flushes the FIFO, the in_flight register, the phase counter, and the output register.
  - Read data still returning from earlier addresses is discarded.

## Timing
- Reset values:
  - busy=0, done=0, pix_valid=0, pix_sol=0, pix_eof=0.
  - pix_R/G/B=0.
  - SRAM_address=BASE_ADDR, SRAM_we_n=1.
- start sampled at edge k (in IDLE): SRAM_address = BASE_ADDR at edge k+1, and busy=1 from edge k+1.
- First word is sampled at edge k+1+RD_LATENCY. First pix_valid is asserted one edge after w1 is popped.
- Throughput: with pix_ready held high, the sustained rate is 2 pixels per 3 cycles, limited by the SRAM rate of one word per cycle. Reads never stall.
- Backpressure:
  - With pix_ready low, reads stop once FIFO_DEPTH words are queued or in flight.
  - Reads resume the cycle after credit frees.
- done: pulses exactly one cycle, at the edge after the handshake of the pixel with pix_eof=1. busy falls on the same edge.
- Simultaneous push and pop in one cycle: fifo_count is unchanged, and the credit calculation uses the registered counts.

## Test plan
- Reset for 3 cycles → all outputs at their reset values, SRAM_we_n=1, no address activity.
- SRAM model with w0=16'hAABB, w1=16'hCCDD, w2=16'hEEFF, start, pix_ready=1:
  - pixel 0 = R=AA G=BB B=CC with pix_sol=1.
  - pixel 1 = R=DD G=EE B=FF.
  - first address 146944.
- Full frame with pix_ready=1:
  - exactly 76800 handshakes.
  - last address issued is 262143.
  - pix_sol every 320 pixels; pix_eof only on pixel 76799.
  - single done pulse.
- pix_ready held low 20 cycles mid-line:
  - SRAM_address stops advancing after at most 8 outstanding words.
  - pix_* remain stable.
  - after release, the pixel sequence continues with no loss or duplication.
- start pulsed at handshake 1000 → ignored; the pixel count and done timing are unchanged.
- Reset asserted at handshake 5000, then start → first address 146944 again, first pixel equals frame pixel 0, no stale pixels emitted.
